scan_line_loader: RTL
=====================

Name: scan_line_loader

Overview:
- Host-side loader directly upstream of the accelerator top.
- Accepts a narrow valid/ready word stream and packs it into 512-bit data and weight lines.
- Drives the top's input-memory scan port (input_mem_scan_mode, scan_addr, data_mem_scan_in, weight_mem_scan_in) one address at a time.
- Replaces bench-driven scan-in for the data and weight SRAMs.

Parameters:
IN_W, 32, host stream word width
LINE_W, 512, scan line width; must equal BEATS*IN_W
BEATS, 16, words per line (LINE_W/IN_W)
DEPTH, 128, maximum lines per load
ADDR_W, 8, scan address width

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-low; reset==0 at posedge clears the block
start  in  1  one-cycle pulse; begins a load when idle
cfg_lines  in  ADDR_W+1  lines to load; 0 means DEPTH; values >DEPTH clamp to DEPTH
s_valid  in  1  host word valid
s_ready  out  1  loader accepts a word this cycle
s_data  in  IN_W  host word
input_mem_scan_mode  out  1  write strobe to top scan port
scan_addr  out  ADDR_W  scan address
data_mem_scan_in  out  LINE_W  assembled data line
weight_mem_scan_in  out  LINE_W  assembled weight line
busy  out  1  high from the cycle after start until return to IDLE
load_done  out  1  sticky completion flag

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - All outputs 0, including line registers, scan_addr, s_ready, busy and load_done.
  - Beat and address counters are 0.
  - Any partial line is discarded and no write is issued.
- States: IDLE, FILL_D, FILL_W, WRITE.
- IDLE:
  - s_ready=0.
  - When start=1: latch the effective line count L (cfg_lines, with 0 mapped to DEPTH and clamp applied).
  - Set addr=0 and beat=0, clear load_done, go to FILL_D.
  - start in any other state is ignored.
- FILL_D:
  - s_ready=1 (combinational from state).
  - On handshake (s_valid&&s_ready), s_data is written to data line bits [beat*IN_W +: IN_W]; beat 0 is the LSBs. beat then increments.
  - The handshake on beat BEATS-1 sets beat=0 and moves to FILL_W.
  - s_valid low stalls indefinitely with no timeout.
- FILL_W:
  - Identical to FILL_D, but targets the weight line.
  - The handshake on beat BEATS-1 moves to WRITE.
- WRITE:
  - s_ready=0.
  - input_mem_scan_mode=1 for exactly this one cycle.
  - scan_addr=addr; data_mem_scan_in and weight_mem_scan_in carry the completed lines.
  - If addr==L-1: set load_done=1 and go to IDLE. Otherwise addr increments and the state goes to FILL_D.
- Latency: last weight beat accepted in cycle N -> input_mem_scan_mode=1 in cycle N+1.
- Output stability:
  - Outputs are registered.
  - scan_addr and both line outputs hold their last values after WRITE until the next line overwrites them.
  - input_mem_scan_mode=0 outside WRITE.
- Address rules: scan_addr never exceeds L-1 and never wraps within a load.
- load_done stays high until the next accepted start or reset.
- busy=1 in FILL_D, FILL_W and WRITE.
- Total cycles per load with no stalls: L*(2*BEATS+1).

Optional Feature:
- Macro: SCAN_LINE_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port load_checksum (IN_W bits).
  - Running wrapping sum mod 2^IN_W of every accepted s_data word.
  - Cleared on reset and on accepted start; updated in the handshake cycle.
  - Final value is valid when load_done rises.
- When undefined: the port and adder are absent; behaviour is otherwise identical.

Test Plan:
1. Reset/idle: hold reset=0 for 3 cycles with s_valid=1 -> s_ready=0, all outputs 0, and no strobe after reset=1 until start.
2. Single line:
   - Stimulus: cfg_lines=1, start; data words 0x00000000..0x0000000F, then weight words 0x100..0x10F, s_valid held high.
   - Response: strobe exactly once, in the cycle after the 32nd handshake.
   - scan_addr=0; data_mem_scan_in[31:0]=0x0, [511:480]=0xF; weight_mem_scan_in[31:0]=0x100.
   - load_done=1 in the next cycle; busy=0.
3. Full load: cfg_lines=0 -> 128 strobes with addr 0..127 in order, 128*33=4224 cycles without stalls, and no address 128.
4. Backpressure: toggle s_valid every cycle with cfg_lines=2 -> line contents equal the unstalled case and exactly 2 strobes occur.
5. Reset mid-load: reset=0 after 10 data beats of line 0 -> no strobe, outputs cleared; a fresh start then loads correctly from addr 0.
6. Clamp and ignore:
   - cfg_lines=200 -> exactly 128 lines written.
   - A start pulse during FILL_W is ignored (L and addr unchanged).
   - With SCAN_LINE_LOADER_CHECKSUM_EN defined, words 1..32 give load_checksum=0x210.

Source files
------------

// File: rtl/scan_line_loader_if.sv
// Host word stream and accelerator input-memory scan port seen by scan_line_loader.
// slave = loader side, master = host/top side.
interface scan_line_loader_if #(
   parameter int unsigned IN_W   = 32,
   parameter int unsigned LINE_W = 512,
   parameter int unsigned ADDR_W = 8
) ();

   logic              s_valid;
   logic              s_ready;
   logic [IN_W-1:0]   s_data;
   logic              input_mem_scan_mode;
   logic [ADDR_W-1:0] scan_addr;
   logic [LINE_W-1:0] data_mem_scan_in;
   logic [LINE_W-1:0] weight_mem_scan_in;

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready,
      output input_mem_scan_mode,
      output scan_addr,
      output data_mem_scan_in,
      output weight_mem_scan_in
   );

   modport master (
      output s_valid,
      output s_data,
      input  s_ready,
      input  input_mem_scan_mode,
      input  scan_addr,
      input  data_mem_scan_in,
      input  weight_mem_scan_in
   );

endinterface

// File: rtl/scan_line_loader.sv
// Packs a narrow host word stream into 512-bit data/weight lines and writes them
// through the accelerator scan port. Optional SCAN_LINE_LOADER_CHECKSUM_EN adds load_checksum.
module scan_line_loader #(
   parameter int unsigned IN_W   = 32,
   parameter int unsigned LINE_W = 512,
   parameter int unsigned BEATS  = 16,
   parameter int unsigned DEPTH  = 128,
   parameter int unsigned ADDR_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W:0]      cfg_lines,
   scan_line_loader_if.slave    bus,
   output logic                 busy,
   output logic                 load_done
`ifdef SCAN_LINE_LOADER_CHECKSUM_EN
   ,
   output logic [IN_W-1:0]      load_checksum
`endif
);

   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned LSB_W  = $clog2(LINE_W);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FILL_D = 2'd1;
   localparam logic [1:0] FILL_W = 2'd2;
   localparam logic [1:0] WRITE  = 2'd3;

   logic [1:0]        state_q,     state_d;
   logic [BEAT_W-1:0] beat_q,      beat_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [LINE_W-1:0] dbuf_q,      dbuf_d;
   logic [LINE_W-1:0] wbuf_q,      wbuf_d;
   logic              s_ready_q,   s_ready_d;
   logic              mode_q,      mode_d;
   logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
   logic [LINE_W-1:0] dout_q,      dout_d;
   logic [LINE_W-1:0] wout_q,      wout_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
`ifdef SCAN_LINE_LOADER_CHECKSUM_EN
   logic [IN_W-1:0]   sum_q,       sum_d;
`endif

   logic              hs;
   logic              last_beat;
   logic [LSB_W-1:0]  lsb;
   logic [CNT_W-1:0]  eff_lines;

   assign hs        = bus.s_valid && s_ready_q;
   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
   assign lsb       = LSB_W'(beat_q) * LSB_W'(IN_W);

   // Zero and oversize requests both mean a full-depth load
   assign eff_lines = ((cfg_lines == '0) || (cfg_lines > CNT_W'(DEPTH))) ? CNT_W'(DEPTH) : cfg_lines;

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      addr_d      = addr_q;
      last_addr_d = last_addr_q;
      dbuf_d      = dbuf_q;
      wbuf_d      = wbuf_q;
      mode_d      = 1'b0;
      scan_addr_d = scan_addr_q;
      dout_d      = dout_q;
      wout_d      = wout_q;
      done_d      = done_q;
`ifdef SCAN_LINE_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
      if (hs) begin
         sum_d = sum_q + bus.s_data;
      end
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               last_addr_d = ADDR_W'(eff_lines - CNT_W'(1));
               addr_d      = '0;
               beat_d      = '0;
               done_d      = 1'b0;
`ifdef SCAN_LINE_LOADER_CHECKSUM_EN
               sum_d       = '0;
`endif
               state_d     = FILL_D;
            end
         end

         FILL_D: begin
            if (hs) begin
               dbuf_d[lsb +: IN_W] = bus.s_data;
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = FILL_W;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end

         FILL_W: begin
            if (hs) begin
               wbuf_d[lsb +: IN_W] = bus.s_data;
               if (last_beat) begin
                  // Capture the lines now so the strobe lands in the very next cycle
                  beat_d      = '0;
                  state_d     = WRITE;
                  mode_d      = 1'b1;
                  scan_addr_d = addr_q;
                  dout_d      = dbuf_q;
                  wout_d      = wbuf_d;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end

         WRITE: begin
            if (addr_q == last_addr_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = FILL_D;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      s_ready_d = (state_d == FILL_D) || (state_d == FILL_W);
      busy_d    = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         addr_q      <= '0;
         last_addr_q <= '0;
         dbuf_q      <= '0;
         wbuf_q      <= '0;
         s_ready_q   <= 1'b0;
         mode_q      <= 1'b0;
         scan_addr_q <= '0;
         dout_q      <= '0;
         wout_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SCAN_LINE_LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         addr_q      <= addr_d;
         last_addr_q <= last_addr_d;
         dbuf_q      <= dbuf_d;
         wbuf_q      <= wbuf_d;
         s_ready_q   <= s_ready_d;
         mode_q      <= mode_d;
         scan_addr_q <= scan_addr_d;
         dout_q      <= dout_d;
         wout_q      <= wout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef SCAN_LINE_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign bus.s_ready             = s_ready_q;
   assign bus.input_mem_scan_mode = mode_q;
   assign bus.scan_addr           = scan_addr_q;
   assign bus.data_mem_scan_in    = dout_q;
   assign bus.weight_mem_scan_in  = wout_q;
   assign busy                    = busy_q;
   assign load_done               = done_q;
`ifdef SCAN_LINE_LOADER_CHECKSUM_EN
   assign load_checksum           = sum_q;
`endif

endmodule
